// File: rtl/safe_keypad_ctrl_pkg.sv
// Shared state encodings and elaboration-time helpers for the keypad safe controller.
package safe_keypad_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_LOCKED  = 3'd0,
      ST_ENTRY   = 3'd1,
      ST_CHECK   = 3'd2,
      ST_OPEN    = 3'd3,
      ST_PROG    = 3'd4,
      ST_LOCKOUT = 3'd5
   } state_e;

   function automatic int code_w(input int code_len, input int digit_w);
      return code_len * digit_w;
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // One bit minimum so a degenerate 1-cycle configuration still elaborates.
   function automatic int timer_w(input int a, input int b, input int c);
      int m;
      m = max3(a, b, c);
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/safe_keypad_ctrl_timer.sv
// Loadable down-counter with zero flag; shared by the open, lockout and error-hold intervals.
module safe_keypad_ctrl_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         zero_o
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Next count: a load wins, otherwise decrement and park at zero.
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (count_q != {W{1'b0}}) begin
         count_d = count_q - {{(W-1){1'b0}}, 1'b1};
      end else begin
         count_d = count_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= {W{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign zero_o = (count_q == {W{1'b0}});

endmodule

// File: rtl/safe_keypad_ctrl.sv
// Keypad safe controller: code entry and check, failed-attempt lockout, timed relock, re-programming.
module safe_keypad_ctrl
   import safe_keypad_ctrl_pkg::*;
#(
   parameter int                             DIGIT_W        = 4,
   parameter int                             CODE_LEN       = 4,
   parameter logic [CODE_LEN*DIGIT_W-1:0]    DEFAULT_CODE   = 16'h1234,
   parameter int                             MAX_FAILS      = 3,
   parameter int                             OPEN_CYCLES    = 1000,
   parameter int                             LOCKOUT_CYCLES = 5000,
   parameter int                             ERR_CYCLES     = 50
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             key_valid,
   input  logic [DIGIT_W-1:0]               key_val,
   input  logic                             key_enter,
   input  logic                             key_clear,
   input  logic                             key_prog,
   output logic                             lock,
   output logic                             green,
   output logic                             blue,
   output logic                             lockout,
   output logic [$clog2(MAX_FAILS+1)-1:0]   fail_cnt,
   output logic [2:0]                       state_o
);

   localparam int CODE_W = code_w(CODE_LEN, DIGIT_W);
   localparam int DCNT_W = $clog2(CODE_LEN + 2);
   localparam int FAIL_W = $clog2(MAX_FAILS + 1);
   localparam int TMR_W  = timer_w(OPEN_CYCLES, LOCKOUT_CYCLES, ERR_CYCLES);

   localparam logic [DCNT_W-1:0] DCNT_FULL = DCNT_W'(CODE_LEN);
   localparam logic [DCNT_W-1:0] DCNT_OVF  = DCNT_W'(CODE_LEN + 1);
   localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_FAILS - 1);
   localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_FAILS);
   localparam logic [TMR_W-1:0]  T_OPEN    = TMR_W'(OPEN_CYCLES - 1);
   localparam logic [TMR_W-1:0]  T_LOCKOUT = TMR_W'(LOCKOUT_CYCLES - 1);
   localparam logic [TMR_W-1:0]  T_ERR     = TMR_W'(ERR_CYCLES - 1);

   state_e              state_q, state_d;
   logic [CODE_W-1:0]   code_q, code_d;
   logic [CODE_W-1:0]   buf_q, buf_d;
   logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
   logic [FAIL_W-1:0]   fail_q, fail_d;
   logic                err_q, err_d;
   logic                match_q;
   logic                lock_q, green_q, blue_q, lockout_q;

   logic                do_clear_s, do_enter_s, do_prog_s, do_digit_s;
   logic [CODE_W-1:0]   buf_shift_s;
   logic [DCNT_W-1:0]   dcnt_inc_s;
   logic                match_s;
   logic                tmr_load_s;
   logic [TMR_W-1:0]    tmr_val_s;
   logic                tmr_zero_s;

   // Only the highest-priority strobe in a cycle is acted on: clear > enter > prog > digit.
   assign do_clear_s = key_clear;
   assign do_enter_s = key_enter & ~key_clear;
   assign do_prog_s  = key_prog & ~key_enter & ~key_clear;
   assign do_digit_s = key_valid & ~key_prog & ~key_enter & ~key_clear;

   assign buf_shift_s = (buf_q << DIGIT_W) | CODE_W'(key_val);
   assign dcnt_inc_s  = (dcnt_q == DCNT_OVF) ? dcnt_q : (dcnt_q + DCNT_W'(1));
   assign match_s     = (dcnt_q == DCNT_FULL) && (buf_q == code_q);

   safe_keypad_ctrl_timer #(
      .W (TMR_W)
   ) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (tmr_load_s),
      .load_val_i (tmr_val_s),
      .zero_o     (tmr_zero_s)
   );

   // Next-state, datapath and timer-load decode.
   always_comb begin
      state_d    = state_q;
      code_d     = code_q;
      buf_d      = buf_q;
      dcnt_d     = dcnt_q;
      fail_d     = fail_q;
      err_d      = err_q;
      tmr_load_s = 1'b0;
      tmr_val_s  = {TMR_W{1'b0}};

      // The error hold expires on its own unless a state below reloads the timer.
      if (err_q && tmr_zero_s) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q;
      end

      case (state_q)
         ST_LOCKED: begin
            if (do_digit_s) begin
               state_d = ST_ENTRY;
               buf_d   = buf_shift_s;
               dcnt_d  = dcnt_inc_s;
            end else begin
               state_d = ST_LOCKED;
            end
         end
         ST_ENTRY: begin
            if (do_clear_s) begin
               state_d = ST_LOCKED;
               buf_d   = {CODE_W{1'b0}};
               dcnt_d  = {DCNT_W{1'b0}};
            end else if (do_enter_s) begin
               state_d = ST_CHECK;
            end else if (do_digit_s) begin
               buf_d  = buf_shift_s;
               dcnt_d = dcnt_inc_s;
            end else begin
               state_d = ST_ENTRY;
            end
         end
         ST_CHECK: begin
            buf_d      = {CODE_W{1'b0}};
            dcnt_d     = {DCNT_W{1'b0}};
            tmr_load_s = 1'b1;
            if (match_q) begin
               state_d   = ST_OPEN;
               fail_d    = {FAIL_W{1'b0}};
               err_d     = 1'b0;
               tmr_val_s = T_OPEN;
            end else if (fail_q == FAIL_LAST) begin
               state_d   = ST_LOCKOUT;
               fail_d    = FAIL_MAX;
               err_d     = 1'b0;
               tmr_val_s = T_LOCKOUT;
            end else begin
               state_d   = ST_LOCKED;
               fail_d    = fail_q + FAIL_W'(1);
               err_d     = 1'b1;
               tmr_val_s = T_ERR;
            end
         end
         ST_OPEN: begin
            if (do_clear_s || tmr_zero_s) begin
               state_d = ST_LOCKED;
            end else if (do_prog_s) begin
               state_d = ST_PROG;
               buf_d   = {CODE_W{1'b0}};
               dcnt_d  = {DCNT_W{1'b0}};
            end else begin
               state_d = ST_OPEN;
            end
         end
         ST_PROG: begin
            if (do_clear_s) begin
               state_d = ST_LOCKED;
               buf_d   = {CODE_W{1'b0}};
               dcnt_d  = {DCNT_W{1'b0}};
            end else if (do_enter_s) begin
               // A short or overflowed entry leaves the stored code untouched.
               if (dcnt_q == DCNT_FULL) begin
                  code_d = buf_q;
               end else begin
                  code_d = code_q;
               end
               state_d = ST_LOCKED;
               buf_d   = {CODE_W{1'b0}};
               dcnt_d  = {DCNT_W{1'b0}};
            end else if (do_digit_s) begin
               buf_d  = buf_shift_s;
               dcnt_d = dcnt_inc_s;
            end else begin
               state_d = ST_PROG;
            end
         end
         ST_LOCKOUT: begin
            if (tmr_zero_s) begin
               state_d = ST_LOCKED;
               fail_d  = {FAIL_W{1'b0}};
            end else begin
               state_d = ST_LOCKOUT;
            end
         end
         default: begin
            state_d = ST_LOCKED;
            buf_d   = {CODE_W{1'b0}};
            dcnt_d  = {DCNT_W{1'b0}};
            err_d   = 1'b0;
         end
      endcase
   end

   // State, datapath and output registers; outputs decode the next state so they align with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_LOCKED;
         code_q    <= DEFAULT_CODE;
         buf_q     <= {CODE_W{1'b0}};
         dcnt_q    <= {DCNT_W{1'b0}};
         fail_q    <= {FAIL_W{1'b0}};
         err_q     <= 1'b0;
         match_q   <= 1'b0;
         lock_q    <= 1'b1;
         green_q   <= 1'b0;
         blue_q    <= 1'b0;
         lockout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         code_q    <= code_d;
         buf_q     <= buf_d;
         dcnt_q    <= dcnt_d;
         fail_q    <= fail_d;
         err_q     <= err_d;
         match_q   <= match_s;
         lock_q    <= ~((state_d == ST_OPEN) || (state_d == ST_PROG));
         green_q   <= (state_d == ST_OPEN);
         blue_q    <= err_d || (state_d == ST_PROG) || (state_d == ST_LOCKOUT);
         lockout_q <= (state_d == ST_LOCKOUT);
      end
   end

   assign lock     = lock_q;
   assign green    = green_q;
   assign blue     = blue_q;
   assign lockout  = lockout_q;
   assign fail_cnt = fail_q;
   assign state_o  = state_q;

endmodule

// File: tb/tb_safe_keypad_ctrl.sv
// Directed self-checking bench for safe_keypad_ctrl with shortened timing parameters.
module tb_safe_keypad_ctrl;

   logic       clk;
   logic       rst_n;
   logic       key_valid;
   logic [3:0] key_val;
   logic       key_enter;
   logic       key_clear;
   logic       key_prog;
   logic       lock;
   logic       green;
   logic       blue;
   logic       lockout;
   logic [1:0] fail_cnt;
   logic [2:0] state_o;

   int checks;
   int errors;

   // {lock, green, blue, lockout, state}
   logic [6:0] obs;
   assign obs = {lock, green, blue, lockout, state_o};

   safe_keypad_ctrl #(
      .DIGIT_W        (4),
      .CODE_LEN       (4),
      .DEFAULT_CODE   (16'h1234),
      .MAX_FAILS      (3),
      .OPEN_CYCLES    (20),
      .LOCKOUT_CYCLES (40),
      .ERR_CYCLES     (5)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_valid (key_valid),
      .key_val   (key_val),
      .key_enter (key_enter),
      .key_clear (key_clear),
      .key_prog  (key_prog),
      .lock      (lock),
      .green     (green),
      .blue      (blue),
      .lockout   (lockout),
      .fail_cnt  (fail_cnt),
      .state_o   (state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Called at a negedge; the strobe is held for exactly one rising edge.
   task automatic press(input logic v, input logic e, input logic c, input logic p, input logic [3:0] d);
      key_valid = v;
      key_enter = e;
      key_clear = c;
      key_prog  = p;
      key_val   = d;
      @(negedge clk);
      key_valid = 1'b0;
      key_enter = 1'b0;
      key_clear = 1'b0;
      key_prog  = 1'b0;
      key_val   = 4'd0;
   endtask

   task automatic digits(input logic [15:0] code, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         press(1'b1, 1'b0, 1'b0, 1'b0, code[i*4 +: 4]);
      end
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      key_valid = 1'b0;
      key_enter = 1'b0;
      key_clear = 1'b0;
      key_prog  = 1'b0;
      key_val   = 4'd0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (obs !== 7'b1000_000) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected %b", obs, 7'b1000_000);
      end
      checks++;
      if (fail_cnt !== 2'd0) begin
         errors++;
         $display("FAIL reset_fail_cnt: got %0d expected 0", fail_cnt);
      end
   endtask

   task automatic test_open();
      do_reset();
      digits(16'h1234, 4);
      press(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      checks++;
      if (obs !== 7'b1000_010) begin
         errors++;
         $display("FAIL open_check_cycle: got %b expected %b", obs, 7'b1000_010);
      end
      @(negedge clk);
      checks++;
      if (obs !== 7'b0100_011) begin
         errors++;
         $display("FAIL open_first: got %b expected %b", obs, 7'b0100_011);
      end
      repeat (19) @(negedge clk);
      checks++;
      if (obs !== 7'b0100_011) begin
         errors++;
         $display("FAIL open_last: got %b expected %b", obs, 7'b0100_011);
      end
      @(negedge clk);
      checks++;
      if (obs !== 7'b1000_000) begin
         errors++;
         $display("FAIL open_relock: got %b expected %b", obs, 7'b1000_000);
      end
   endtask

   task automatic test_mismatch();
      do_reset();
      digits(16'h1235, 4);
      checks++;
      if (obs !== 7'b1000_001) begin
         errors++;
         $display("FAIL mm_entry: got %b expected %b", obs, 7'b1000_001);
      end
      press(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      @(negedge clk);
      checks++;
      if (obs !== 7'b1010_000 || fail_cnt !== 2'd1) begin
         errors++;
         $display("FAIL mm_blue_on: got %b/%0d expected %b/1", obs, fail_cnt, 7'b1010_000);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (obs !== 7'b1010_000) begin
         errors++;
         $display("FAIL mm_blue_last: got %b expected %b", obs, 7'b1010_000);
      end
      @(negedge clk);
      checks++;
      if (obs !== 7'b1000_000 || fail_cnt !== 2'd1) begin
         errors++;
         $display("FAIL mm_blue_off: got %b/%0d expected %b/1", obs, fail_cnt, 7'b1000_000);
      end
   endtask

   task automatic test_lockout();
      do_reset();
      digits(16'h1235, 4);
      press(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      @(negedge clk);
      digits(16'h1235, 4);
      press(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      @(negedge clk);
      checks++;
      if (fail_cnt !== 2'd2) begin
         errors++;
         $display("FAIL lo_fail2: got %0d expected 2", fail_cnt);
      end
      digits(16'h1235, 4);
      press(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      @(negedge clk);
      checks++;
      if (obs !== 7'b1011_101) begin
         errors++;
         $display("FAIL lo_enter: got %b expected %b", obs, 7'b1011_101);
      end
      digits(16'h1234, 4);
      press(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      checks++;
      if (obs !== 7'b1011_101) begin
         errors++;
         $display("FAIL lo_keys_ignored: got %b expected %b", obs, 7'b1011_101);
      end
      repeat (34) @(negedge clk);
      checks++;
      if (obs !== 7'b1011_101) begin
         errors++;
         $display("FAIL lo_last: got %b expected %b", obs, 7'b1011_101);
      end
      @(negedge clk);
      checks++;
      if (obs !== 7'b1000_000 || fail_cnt !== 2'd0) begin
         errors++;
         $display("FAIL lo_exit: got %b/%0d expected %b/0", obs, fail_cnt, 7'b1000_000);
      end
   endtask

   task automatic test_prog();
      do_reset();
      digits(16'h1234, 4);
      press(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      @(negedge clk);
      press(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
      checks++;
      if (obs !== 7'b0010_100) begin
         errors++;
         $display("FAIL prog_enter: got %b expected %b", obs, 7'b0010_100);
      end
      digits(16'h9876, 4);
      press(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      checks++;
      if (obs !== 7'b1000_000) begin
         errors++;
         $display("FAIL prog_done: got %b expected %b", obs, 7'b1000_000);
      end
      digits(16'h1234, 4);
      press(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      @(negedge clk);
      checks++;
      if (obs !== 7'b1010_000 || fail_cnt !== 2'd1) begin
         errors++;
         $display("FAIL prog_old_rejected: got %b/%0d expected %b/1", obs, fail_cnt, 7'b1010_000);
      end
      digits(16'h9876, 4);
      press(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      @(negedge clk);
      checks++;
      if (obs !== 7'b0100_011 || fail_cnt !== 2'd0) begin
         errors++;
         $display("FAIL prog_new_opens: got %b/%0d expected %b/0", obs, fail_cnt, 7'b0100_011);
      end
      // Short programming entry must keep the default code.
      do_reset();
      digits(16'h1234, 4);
      press(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      @(negedge clk);
      press(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
      digits(16'h0123, 3);
      press(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      digits(16'h1234, 4);
      press(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      @(negedge clk);
      checks++;
      if (obs !== 7'b0100_011) begin
         errors++;
         $display("FAIL prog_short_kept: got %b expected %b", obs, 7'b0100_011);
      end
   endtask

   task automatic test_overflow_priority();
      do_reset();
      digits(16'h2345, 4);
      press(1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
      press(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      @(negedge clk);
      checks++;
      if (obs !== 7'b1010_000 || fail_cnt !== 2'd1) begin
         errors++;
         $display("FAIL ovf_mismatch: got %b/%0d expected %b/1", obs, fail_cnt, 7'b1010_000);
      end
      press(1'b1, 1'b0, 1'b0, 1'b0, 4'd7);
      checks++;
      if (state_o !== 3'd1) begin
         errors++;
         $display("FAIL prio_digit_in_hold: got %0d expected 1", state_o);
      end
      press(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
      repeat (2) @(negedge clk);
      checks++;
      if (state_o !== 3'd0 || fail_cnt !== 2'd1) begin
         errors++;
         $display("FAIL prio_clear_enter: got %0d/%0d expected 0/1", state_o, fail_cnt);
      end
      press(1'b1, 1'b0, 1'b1, 1'b0, 4'd3);
      checks++;
      if (state_o !== 3'd0) begin
         errors++;
         $display("FAIL prio_clear_valid_locked: got %0d expected 0", state_o);
      end
   endtask

   task automatic test_reset_mid_open();
      do_reset();
      digits(16'h1234, 4);
      press(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      @(negedge clk);
      press(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
      digits(16'h9876, 4);
      press(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      digits(16'h9876, 4);
      press(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      @(negedge clk);
      checks++;
      if (obs !== 7'b0100_011) begin
         errors++;
         $display("FAIL rst_pre_open: got %b expected %b", obs, 7'b0100_011);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (obs !== 7'b1000_000 || fail_cnt !== 2'd0) begin
         errors++;
         $display("FAIL rst_async: got %b/%0d expected %b/0", obs, fail_cnt, 7'b1000_000);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      digits(16'h1234, 4);
      press(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      @(negedge clk);
      checks++;
      if (obs !== 7'b0100_011) begin
         errors++;
         $display("FAIL rst_default_code: got %b expected %b", obs, 7'b0100_011);
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      key_valid = 1'b0;
      key_enter = 1'b0;
      key_clear = 1'b0;
      key_prog  = 1'b0;
      key_val   = 4'd0;
      test_reset();
      test_open();
      test_mismatch();
      test_lockout();
      test_prog();
      test_overflow_priority();
      test_reset_mid_open();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
